cnn_csr_axil: RTL

AXI4-Lite slave register file that sits directly upstream of the CNN accelerator top. It presents the CPU-visible control/status registers: start, two instruction words, three DDR base addresses and two DMA-to-kernel limits. It drives these as static 32-bit levels into the accelerator and consumes its `cnn_over` completion pulse to clear START and post a sticky DONE flag.

---
 rtl/cnn_csr_pkg.sv | 40 ++++
 rtl/cnn_csr_axil.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_csr_pkg.sv
// cnn_csr_pkg
//   Shared definitions for the CNN accelerator CSR block: register byte
//   offsets, AXI response codes, STATUS bit positions and a byte-lane
//   merge helper used by the register bank.
package cnn_csr_pkg;

    localparam int OFF_W   = 6;
    localparam int NUM_CFG = 7;

    localparam logic [OFF_W-1:0] CSR_START        = 6'h00;
    localparam logic [OFF_W-1:0] CSR_INS_A        = 6'h04;
    localparam logic [OFF_W-1:0] CSR_INS_B        = 6'h08;
    localparam logic [OFF_W-1:0] CSR_R_ADDR       = 6'h0C;
    localparam logic [OFF_W-1:0] CSR_W_ADDR       = 6'h10;
    localparam logic [OFF_W-1:0] CSR_WEIGHT_ADDR  = 6'h14;
    localparam logic [OFF_W-1:0] CSR_DATA_LIMIT   = 6'h18;
    localparam logic [OFF_W-1:0] CSR_WEIGHT_LIMIT = 6'h1C;
    localparam logic [OFF_W-1:0] CSR_STATUS       = 6'h20;
    localparam logic [OFF_W-1:0] CSR_IRQ_EN       = 6'h24;
    localparam logic [OFF_W-1:0] CSR_VERSION      = 6'h28;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cnn_csr_axil.sv
// cnn_csr_axil
//   AXI4-Lite slave register file in front of the CNN accelerator.
//   Holds START, two instruction words, three DDR base addresses and two
//   DMA-to-kernel limits, drives them as static levels, and turns the
//   accelerator's cnn_over rising edge into START clear + sticky DONE.
//   Optional feature macro: CNN_CSR_IRQ_EN adds the IRQ_EN register (0x24)
//   and the registered level interrupt output irq.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*           AXI4-Lite write address / data / response
//   s_ar*/s_r*                AXI4-Lite read address / data
//   cpu_*                     32-bit register levels to the accelerator
//   cnn_over                  accelerator completion level
//   irq                       DONE & IRQ_EN[0], registered (macro only)
// Decode uses the low 6 address bits; unaligned offsets are unmapped.
module cnn_csr_axil
    import cnn_csr_pkg::*;
#(
    parameter int          ADDR_W  = 6,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       cpu_start,
    output logic [31:0]       cpu_ins_a,
    output logic [31:0]       cpu_ins_b,
    output logic [31:0]       cpu_r_addr,
    output logic [31:0]       cpu_w_addr,
    output logic [31:0]       cpu_weight_addr,
    output logic [31:0]       cpu_data_dma2kernel_limit,
    output logic [31:0]       cpu_weight_dma2kernel_limit,
    input  logic              cnn_over
`ifdef CNN_CSR_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic             aw_held_q, aw_held_d;
    logic [OFF_W-1:0] awaddr_q, awaddr_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             over_q;
    logic [31:0]      cfg_q [NUM_CFG];
    logic [31:0]      cfg_d [NUM_CFG];
`ifdef CNN_CSR_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_q;
`endif

    logic             aw_hs, w_hs, ar_hs, over_edge, commit;
    logic [2:0]       aw_idx, ar_idx;
    logic [OFF_W-1:0] ar_off;
    logic [31:0]      rd_data;
    logic [1:0]       rd_resp;

    assign s_awready = !aw_held_q;
    assign s_wready  = !w_held_q;
    assign s_arready = !rvalid_q;
    assign aw_hs     = s_awvalid && !aw_held_q;
    assign w_hs      = s_wvalid && !w_held_q;
    assign ar_hs     = s_arvalid && !rvalid_q;
    assign over_edge = cnn_over && !over_q;
    // A commit colliding with a completion edge waits one cycle, so START is
    // seen low for at least one cycle before a re-start lands.
    assign commit    = aw_held_q && w_held_q && !bvalid_q && !over_edge;
    // Config registers 0x04..0x1C map onto cfg index 0..6.
    assign aw_idx    = awaddr_q[4:2] - 3'd1;
    assign ar_off    = s_araddr[OFF_W-1:0];
    assign ar_idx    = ar_off[4:2] - 3'd1;

    // Write channel holds, response and register bank next state
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        start_d   = start_q;
        done_d    = done_q;
        cfg_d     = cfg_q;
`ifdef CNN_CSR_IRQ_EN
        irq_en_d  = irq_en_q;
`endif
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_awaddr[OFF_W-1:0];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
        end
        if (bvalid_q && s_bready) bvalid_d = 1'b0;
        if (over_edge) begin
            start_d = 1'b0;
            done_d  = 1'b1;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            case (awaddr_q)
                CSR_START: if (wstrb_q[0]) start_d = wdata_q[0];
                CSR_INS_A, CSR_INS_B, CSR_R_ADDR, CSR_W_ADDR,
                CSR_WEIGHT_ADDR, CSR_DATA_LIMIT, CSR_WEIGHT_LIMIT: begin
                    // Job parameters are frozen while the accelerator runs.
                    if (start_q) bresp_d = RESP_SLVERR;
                    else cfg_d[aw_idx] = merge_strb(cfg_q[aw_idx], wdata_q, wstrb_q);
                end
                CSR_STATUS: if (wstrb_q[0] && wdata_q[STATUS_DONE]) done_d = 1'b0;
`ifdef CNN_CSR_IRQ_EN
                CSR_IRQ_EN: if (wstrb_q[0]) irq_en_d = wdata_q[0];
`endif
                default: bresp_d = RESP_SLVERR;
            endcase
        end
    end

    // Read decode, sampled at the AR handshake
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (ar_off)
            CSR_START: rd_data[0] = start_q;
            CSR_INS_A, CSR_INS_B, CSR_R_ADDR, CSR_W_ADDR,
            CSR_WEIGHT_ADDR, CSR_DATA_LIMIT, CSR_WEIGHT_LIMIT: rd_data = cfg_q[ar_idx];
            CSR_STATUS: begin
                rd_data[STATUS_BUSY] = start_q;
                rd_data[STATUS_DONE] = done_q;
            end
`ifdef CNN_CSR_IRQ_EN
            CSR_IRQ_EN: rd_data[0] = irq_en_q;
`endif
            CSR_VERSION: rd_data = VERSION;
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && s_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_resp;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            over_q    <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
`ifdef CNN_CSR_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            start_q   <= start_d;
            done_q    <= done_d;
            over_q    <= cnn_over;
            cfg_q     <= cfg_d;
`ifdef CNN_CSR_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= done_q && irq_en_q;
`endif
        end
    end

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;

    assign cpu_start                   = {31'd0, start_q};
    assign cpu_ins_a                   = cfg_q[0];
    assign cpu_ins_b                   = cfg_q[1];
    assign cpu_r_addr                  = cfg_q[2];
    assign cpu_w_addr                  = cfg_q[3];
    assign cpu_weight_addr             = cfg_q[4];
    assign cpu_data_dma2kernel_limit   = cfg_q[5];
    assign cpu_weight_dma2kernel_limit = cfg_q[6];
`ifdef CNN_CSR_IRQ_EN
    assign irq = irq_q;
`endif

endmodule
